// File: rtl/lm_multichannel.sv
// Multichannel LED manager: per-channel hold/sticky capture feeding a registered display mux.
// Optional blink of sticky channels in fixed/rotate modes is built when LM_BLINK_EN is defined.
module lm_multichannel #(
    parameter int N_CH        = 4,
    parameter int CH_WIDTH    = 8,
    parameter int IDX_W       = 2,
    parameter int WIDTH_LEDS  = 10,
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int ROT_CYCLES  = 100_000_000,
    parameter int BLINK_HALF  = 12_500_000
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic [N_CH*CH_WIDTH-1:0] ch_data_i,
    input  logic [N_CH-1:0]          ch_valid_i,
    input  logic [N_CH-1:0]          ch_sticky_i,
    input  logic                     clear_i,
    input  logic [1:0]               mode_i,
    input  logic [IDX_W-1:0]         sel_i,
    output logic [WIDTH_LEDS-1:0]    leds_o,
    output logic [N_CH-1:0]          ch_active_o
);

    localparam int HT_W   = $clog2(HOLD_CYCLES + 1);
    localparam int ROT_W  = $clog2(ROT_CYCLES + 1);
    localparam int STEP_W = $clog2(N_CH + 1);

    localparam logic [HT_W-1:0]   HOLD_LD   = HT_W'(HOLD_CYCLES);
    localparam logic [HT_W-1:0]   TIMER_ONE = HT_W'(1);
    localparam logic [ROT_W-1:0]  ROT_LAST  = ROT_W'(ROT_CYCLES - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(N_CH - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_CH - 1);

    typedef enum logic {
        DWELL = 1'b0,
        SCAN  = 1'b1
    } rot_st_t;

    logic [CH_WIDTH-1:0]   hold_q  [N_CH];
    logic [CH_WIDTH-1:0]   hold_d  [N_CH];
    logic [HT_W-1:0]       timer_q [N_CH];
    logic [HT_W-1:0]       timer_d [N_CH];
    logic [N_CH-1:0]       active;
    logic [CH_WIDTH-1:0]   or_all;

    rot_st_t               st_q, st_d;
    logic [IDX_W-1:0]      rot_idx_q, rot_idx_d;
    logic [IDX_W-1:0]      scan_idx_q, scan_idx_d;
    logic [STEP_W-1:0]     step_q, step_d;
    logic [ROT_W-1:0]      rot_cnt_q, rot_cnt_d;
    logic                  rot_mode_q;
    logic                  rot_mode;
    logic                  rot_enter;
    logic                  sel_ok;
    logic [IDX_W-1:0]      sel_idx;
    logic [IDX_W-1:0]      cand;
    logic [IDX_W-1:0]      rot_show;

    logic [IDX_W-1:0]      disp_idx;
    logic [CH_WIDTH-1:0]   disp_data;
    logic                  blank;
    logic [WIDTH_LEDS-1:0] leds_q, leds_d;
    logic [N_CH-1:0]       ch_active_q;

    // Capture and hold-timer next state; valid is applied last so it wins over decay and clear.
    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            hold_d[c]  = hold_q[c];
            timer_d[c] = timer_q[c];
            if (timer_q[c] != '0) begin
                timer_d[c] = timer_q[c] - TIMER_ONE;
                if (timer_q[c] == TIMER_ONE && !ch_sticky_i[c]) begin
                    hold_d[c] = '0;
                end
            end
            if (clear_i) begin
                hold_d[c]  = '0;
                timer_d[c] = '0;
            end
            if (ch_valid_i[c]) begin
                if (ch_sticky_i[c]) begin
                    hold_d[c] = clear_i ? ch_data_i[c*CH_WIDTH +: CH_WIDTH]
                                        : (hold_q[c] | ch_data_i[c*CH_WIDTH +: CH_WIDTH]);
                end else begin
                    hold_d[c]  = ch_data_i[c*CH_WIDTH +: CH_WIDTH];
                    timer_d[c] = HOLD_LD;
                end
            end
        end
    end

    always_comb begin
        active = '0;
        or_all = '0;
        for (int c = 0; c < N_CH; c++) begin
            active[c] = |hold_q[c];
            or_all    = or_all | hold_q[c];
        end
    end

    assign sel_ok    = (32'(sel_i) < N_CH);
    assign sel_idx   = sel_ok ? sel_i : '0;
    assign rot_mode  = (mode_i == 2'b01);
    assign rot_enter = rot_mode && !rot_mode_q;
    assign cand      = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + IDX_W'(1);

    // Rotate FSM: state register.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            st_q       <= DWELL;
            rot_idx_q  <= '0;
            scan_idx_q <= '0;
            step_q     <= '0;
            rot_cnt_q  <= '0;
            rot_mode_q <= 1'b0;
        end else begin
            st_q       <= st_d;
            rot_idx_q  <= rot_idx_d;
            scan_idx_q <= scan_idx_d;
            step_q     <= step_d;
            rot_cnt_q  <= rot_cnt_d;
            rot_mode_q <= rot_mode;
        end
    end

    // Rotate FSM: next state. SCAN walks a separate pointer so skipped channels never reach the LEDs.
    always_comb begin
        st_d       = st_q;
        rot_idx_d  = rot_idx_q;
        scan_idx_d = scan_idx_q;
        step_d     = step_q;
        rot_cnt_d  = rot_cnt_q;
        if (!rot_mode) begin
            st_d = DWELL;
        end else if (rot_enter) begin
            st_d      = DWELL;
            rot_idx_d = sel_idx;
            rot_cnt_d = '0;
        end else begin
            case (st_q)
                DWELL: begin
                    if (rot_cnt_q >= ROT_LAST) begin
                        st_d       = SCAN;
                        scan_idx_d = rot_idx_q;
                        step_d     = '0;
                    end else begin
                        rot_cnt_d = rot_cnt_q + ROT_W'(1);
                    end
                end
                SCAN: begin
                    if (active[cand] || step_q == STEP_LAST) begin
                        st_d      = DWELL;
                        rot_idx_d = cand;
                        rot_cnt_d = '0;
                    end else begin
                        scan_idx_d = cand;
                        step_d     = step_q + STEP_W'(1);
                    end
                end
                default: st_d = DWELL;
            endcase
        end
    end

    // Rotate FSM: output. On entry the new index is shown immediately.
    always_comb begin
        rot_show = rot_idx_q;
        if (rot_enter) begin
            rot_show = sel_idx;
        end
    end

    assign disp_idx = rot_mode ? rot_show : sel_i;

`ifdef LM_BLINK_EN
    localparam int BL_W = $clog2(BLINK_HALF + 1);
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_HALF - 1);

    logic [BL_W-1:0] blink_cnt_q;
    logic            blink_ph_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
        end else if (blink_cnt_q >= BL_LAST) begin
            blink_cnt_q <= '0;
            blink_ph_q  <= ~blink_ph_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + BL_W'(1);
        end
    end

    assign blank = blink_ph_q && ch_sticky_i[disp_idx] && (|hold_q[disp_idx]);
`else
    localparam int unused_blink_half = BLINK_HALF;
    assign blank = 1'b0;
`endif

    assign disp_data = blank ? '0 : hold_q[disp_idx];

    always_comb begin
        leds_d = '0;
        case (mode_i)
            2'b00: begin
                if (sel_ok) begin
                    leds_d[CH_WIDTH +: IDX_W]  = disp_idx;
                    leds_d[CH_WIDTH-1:0]       = disp_data;
                end
            end
            2'b01: begin
                if (|active) begin
                    leds_d[CH_WIDTH +: IDX_W]  = disp_idx;
                    leds_d[CH_WIDTH-1:0]       = disp_data;
                end
            end
            2'b10:   leds_d[CH_WIDTH-1:0] = or_all;
            default: leds_d[N_CH-1:0]     = active;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int c = 0; c < N_CH; c++) begin
                hold_q[c]  <= '0;
                timer_q[c] <= '0;
            end
            leds_q      <= '0;
            ch_active_q <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                hold_q[c]  <= hold_d[c];
                timer_q[c] <= timer_d[c];
            end
            leds_q      <= leds_d;
            ch_active_q <= active;
        end
    end

    assign leds_o      = leds_q;
    assign ch_active_o = ch_active_q;

endmodule

// File: tb/tb_lm_multichannel.sv
// Directed bench for lm_multichannel with a scoreboard of expected LED words.
module tb_lm_multichannel;

    localparam int N_CH = 4;
    localparam int CW   = 8;
    localparam int WL   = 10;
    localparam int BH   = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N_CH*CW-1:0] ch_data;
    logic [N_CH-1:0] ch_valid;
    logic [N_CH-1:0] ch_sticky;
    logic            clear;
    logic [1:0]      mode;
    logic [1:0]      sel;
    logic [WL-1:0]   leds;
    logic [N_CH-1:0] ch_active;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    string         tag_q[$];
    logic [WL-1:0] val_q[$];
    bit            blk_q[$];

    always #5 clk = ~clk;

    // Edges since reset release; drives the expected blink phase.
    always @(posedge clk) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    lm_multichannel #(
        .N_CH(4), .CH_WIDTH(8), .IDX_W(2), .WIDTH_LEDS(10),
        .HOLD_CYCLES(5), .ROT_CYCLES(3), .BLINK_HALF(BH)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .ch_data_i(ch_data), .ch_valid_i(ch_valid),
        .ch_sticky_i(ch_sticky), .clear_i(clear), .mode_i(mode), .sel_i(sel),
        .leds_o(leds), .ch_active_o(ch_active)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        string         t;
        logic [WL-1:0] e;
        bit            b;
        @(posedge clk);
        #1;
        if (val_q.size() > 0) begin
            t = tag_q.pop_front();
            e = val_q.pop_front();
            b = blk_q.pop_front();
`ifdef LM_BLINK_EN
            if (b && (((cyc - 1) / BH) % 2 == 1)) e[CW-1:0] = '0;
`else
            if (b) e = e;
`endif
            chk(t, 32'(leds), 32'(e));
        end
    endtask

    task automatic exp_step(input string tag, input logic [WL-1:0] v, input bit blk = 1'b0);
        tag_q.push_back(tag);
        val_q.push_back(v);
        blk_q.push_back(blk);
        step();
    endtask

    task automatic set_ch(input int c, input logic [CW-1:0] d);
        ch_data[c*CW +: CW] = d;
    endtask

    initial begin
        #200_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ch_data   = $urandom;
            ch_valid  = 4'($urandom_range(0, 15));
            ch_sticky = 4'($urandom_range(0, 15));
            clear     = 1'($urandom_range(0, 1));
            mode      = 2'($urandom_range(0, 3));
            sel       = 2'($urandom_range(0, 3));
            step();
        end
        chk("rst_leds", 32'(leds), 32'h0);
        chk("rst_act", 32'(ch_active), 32'h0);
        rst_n = 1'b1; ch_data = '0; ch_valid = '0; ch_sticky = '0;
        clear = 1'b0; mode = 2'b00; sel = 2'd0;
        step();
        chk("rel_leds", 32'(leds), 32'h0);
        chk("rel_act", 32'(ch_active), 32'h0);

        // Non-sticky hold timer on ch1.
        sel = 2'd1; set_ch(1, 8'hA5); ch_valid = 4'b0010;
        exp_step("hold_n", 10'h100);
        ch_valid = '0;
        exp_step("hold_on", 10'h1A5);
        chk("hold_act", 32'(ch_active), 32'h2);
        for (int i = 0; i < 4; i++) exp_step("hold_on", 10'h1A5);
        exp_step("hold_drop", 10'h100);
        chk("hold_act_drop", 32'(ch_active), 32'h0);

        // Re-valid while timer is 1 extends the hold.
        set_ch(1, 8'h5A); ch_valid = 4'b0010;
        exp_step("ext_n", 10'h100);
        ch_valid = '0;
        for (int i = 0; i < 4; i++) exp_step("ext_a", 10'h15A);
        set_ch(1, 8'h3C); ch_valid = 4'b0010;
        exp_step("ext_a", 10'h15A);
        ch_valid = '0;
        for (int i = 0; i < 5; i++) exp_step("ext_b", 10'h13C);
        exp_step("ext_drop", 10'h100);

        // Sticky accumulate, no decay, clear and clear+valid.
        ch_sticky = 4'b0100; sel = 2'd2;
        set_ch(2, 8'h01); ch_valid = 4'b0100;
        exp_step("stk_n", 10'h200);
        set_ch(2, 8'h80);
        exp_step("stk_a", 10'h201, 1'b1);
        ch_valid = '0;
        exp_step("stk_b", 10'h281, 1'b1);
        for (int i = 0; i < 1000; i++) step();
        exp_step("stk_keep", 10'h281, 1'b1);
        clear = 1'b1; set_ch(2, 8'h04); ch_valid = 4'b0100;
        exp_step("clrv_n", 10'h281, 1'b1);
        clear = 1'b0; ch_valid = '0;
        exp_step("clrv", 10'h204, 1'b1);
        chk("clrv_act", 32'(ch_active), 32'h4);
        clear = 1'b1;
        exp_step("clr_n", 10'h204, 1'b1);
        clear = 1'b0;
        exp_step("clr", 10'h200);
        exp_step("clr_hold", 10'h200);

        // Overlay and status.
        ch_sticky = 4'b0011; set_ch(0, 8'h0F); set_ch(1, 8'hF0);
        ch_valid = 4'b0011; mode = 2'b10;
        exp_step("ov_n", 10'h000);
        ch_valid = '0;
        exp_step("overlay", 10'h0FF);
        mode = 2'b11;
        exp_step("status", 10'h003);
        chk("status_act", 32'(ch_active), 32'h3);

        // Rotate with only ch0 and ch3 active.
        clear = 1'b1;
        exp_step("rclr_n", 10'h003);
        clear = 1'b0; ch_sticky = 4'b1001; set_ch(0, 8'h11); set_ch(3, 8'h33);
        ch_valid = 4'b1001; mode = 2'b00; sel = 2'd0;
        exp_step("rld_n", 10'h000);
        ch_valid = '0;
        exp_step("rld", 10'h011, 1'b1);
        mode = 2'b01;
        for (int i = 0; i < 7; i++) exp_step("rot0a", 10'h011, 1'b1);
        for (int i = 0; i < 4; i++) exp_step("rot3a", 10'h333, 1'b1);
        for (int i = 0; i < 6; i++) exp_step("rot0b", 10'h011, 1'b1);
        for (int i = 0; i < 4; i++) exp_step("rot3b", 10'h333, 1'b1);
        clear = 1'b1;
        exp_step("rot_clr_n", 10'h011, 1'b1);
        clear = 1'b0;
        for (int i = 0; i < 4; i++) exp_step("rot_none", 10'h000);

        // Sticky ch1 in fixed mode: steady, or blinking when built with the option.
        mode = 2'b00; sel = 2'd1; ch_sticky = 4'b0010;
        set_ch(1, 8'h3C); ch_valid = 4'b0010;
        exp_step("bl_n", 10'h100);
        ch_valid = '0;
        for (int i = 0; i < 16; i++) exp_step("blink", 10'h13C, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
